fetch_buffer: RTL and testbench

//  Decoupling buffer between the fetch stage and the decode stage.
//  - Pairs each issued fetch (PC/exception metadata on fs_to_ds_bus) with the instruction SRAM read data, which returns one cycle later.
//  - Queues the paired result in a small FIFO so no instruction is lost while decode stalls.
//  - Presents the FIFO head to decode and raises a back-pressure request so fetch holds its PC.

---
 rtl/fetch_buffer_pkg.sv | 36 +++
 rtl/fetch_buffer_chk.sv | 12 +
 rtl/fetch_buffer_sync_fifo.sv | 60 ++++++
 rtl/fetch_buffer.sv | 85 ++++++++
 tb/tb_fetch_buffer.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_buffer_pkg.sv
// Shared bus widths, field offsets and entry layout for the fetch -> decode path.
// The fetch and decode stages import the same definitions.
package fetch_buffer_pkg;

  localparam int FS_TO_DS_BUS_WD = 65;
  localparam int FB_TO_DS_BUS_WD = 97;

  localparam int PC_LSB   = 0;
  localparam int INST_LSB = 32;
  localparam int ADEF_BIT = 64;
  localparam int VEC_LSB  = 65;

  // Field positions inside the fetch metadata bus
  localparam int FS_ADEF_BIT = 32;
  localparam int FS_VEC_LSB  = 33;

  typedef struct packed {
    logic [31:0] csr_vec_h;
    logic        excp_adef;
    logic [31:0] inst;
    logic [31:0] pc;
  } fb_entry_t;

  function automatic logic [FB_TO_DS_BUS_WD-1:0] pack_entry(
    input logic [FS_TO_DS_BUS_WD-1:0] meta,
    input logic [31:0]                inst
  );
    fb_entry_t e;
    e.csr_vec_h = meta[FS_VEC_LSB +: 32];
    e.excp_adef = meta[FS_ADEF_BIT];
    e.inst      = inst;
    e.pc        = meta[PC_LSB +: 32];
    return e;
  endfunction

endpackage

// File: rtl/fetch_buffer_chk.sv
// Protocol checker: the in-flight response must always find a free FIFO slot.
module fetch_buffer_chk (
  input logic clk,
  input logic reset,
  input logic push,
  input logic pop,
  input logic full
);

  push_into_full_a: assert property (@(posedge clk) disable iff (reset) !(push && full && !pop));

endmodule

// File: rtl/fetch_buffer_sync_fifo.sv
// Register-array FIFO with synchronous clear; pointers wrap naturally at DEPTH.
module sync_fifo #(
  parameter int WIDTH = 97,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             wr_en_s;
  logic             rd_en_s;

  // Status flags and qualified enables; a write into a full FIFO only lands when a pop frees a slot
  always_comb begin
    empty   = (count_r == {(AW+1){1'b0}});
    full    = (count_r == DEPTH_C);
    rd_en_s = pop & ~empty;
    wr_en_s = push & (~full | rd_en_s);
    rdata   = mem_r[rd_ptr_r];
    count   = count_r;
  end

  // Pointer and occupancy state
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      if (rd_en_s) rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      case ({wr_en_s, rd_en_s})
        2'b10:   count_r <= count_r + (AW+1)'(1'b1);
        2'b01:   count_r <= count_r - (AW+1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array, deliberately left without reset
  always_ff @(posedge clk) begin
    if (wr_en_s && !reset && !clear) mem_r[wr_ptr_r] <= wdata;
  end

endmodule

// File: rtl/fetch_buffer.sv
// Fetch/decode decoupling buffer: pairs each fetch with the SRAM data returning one
// cycle later, queues the result and back-pressures fetch when no slot is guaranteed.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [5:0]                 stall,
  input  logic                       fs_req,
  input  logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  input  logic [31:0]                inst_sram_rdata,
  output logic                       fb_stall_req,
  output logic                       ds_valid,
  output logic [FB_TO_DS_BUS_WD-1:0] fb_to_ds_bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic                       inflight_v_r;
  logic [FS_TO_DS_BUS_WD-1:0] inflight_meta_r;
  logic                       push_s;
  logic                       pop_s;
  logic [FB_TO_DS_BUS_WD-1:0] wdata_s;
  logic [FB_TO_DS_BUS_WD-1:0] head_s;
  logic [CW-1:0]              count_s;
  logic [CW:0]                occupancy_s;
  logic                       empty_s;
  logic                       full_s;
  logic                       unused_stall_s;

  assign unused_stall_s = ^{stall[5:2], stall[0]};

  // Inflight register: a flush-cycle request carries a stale PC and is dropped
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      inflight_v_r <= 1'b0;
    end else begin
      inflight_v_r <= fs_req;
      if (fs_req) inflight_meta_r <= fs_to_ds_bus;
    end
  end

  // Push/pop qualification, entry packing and back-pressure from registered state only
  always_comb begin
    push_s       = inflight_v_r & ~flush;
    pop_s        = ~empty_s & ~stall[1] & ~flush;
    wdata_s      = pack_entry(inflight_meta_r, inst_sram_rdata);
    occupancy_s  = {1'b0, count_s} + {{CW{1'b0}}, inflight_v_r};
    fb_stall_req = (occupancy_s >= (CW+1)'(DEPTH));
    ds_valid     = ~empty_s;
    if (ds_valid) begin
      fb_to_ds_bus = head_s;
    end else begin
      fb_to_ds_bus = {FB_TO_DS_BUS_WD{1'b0}};
    end
  end

  sync_fifo #(
    .WIDTH (FB_TO_DS_BUS_WD),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .clear (flush),
    .wdata (wdata_s),
    .rdata (head_s),
    .count (count_s),
    .empty (empty_s),
    .full  (full_s)
  );

  fetch_buffer_chk u_chk (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .full  (full_s)
  );

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: directed vector table, a steady-stream sequence and
// randomized traffic checked against a queue-based reference model.
module tb_fetch_buffer;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [5:0]  stall;
  logic        fs_req;
  logic [64:0] fs_to_ds_bus;
  logic [31:0] inst_sram_rdata;
  logic        fb_stall_req;
  logic        ds_valid;
  logic [96:0] fb_to_ds_bus;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .flush           (flush),
    .stall           (stall),
    .fs_req          (fs_req),
    .fs_to_ds_bus    (fs_to_ds_bus),
    .inst_sram_rdata (inst_sram_rdata),
    .fb_stall_req    (fb_stall_req),
    .ds_valid        (ds_valid),
    .fb_to_ds_bus    (fb_to_ds_bus)
  );

  typedef struct {
    logic        rst, fl, st, rq;
    logic [31:0] pc;
    logic        adef;
    logic [31:0] vec;
    logic [31:0] rdata;
    logic        chk, chk_bus, ev, es;
    logic [31:0] epc, einst;
    logic        eadef;
    logic [31:0] evec;
  } vec_t;

  function automatic vec_t mk(input logic rst, fl, st, rq, input logic [31:0] pc,
                              input logic adef, input logic [31:0] vec, rdata,
                              input logic chk, chk_bus, ev, es,
                              input logic [31:0] epc, einst, input logic eadef,
                              input logic [31:0] evec);
    vec_t v;
    v.rst = rst; v.fl = fl; v.st = st; v.rq = rq; v.pc = pc; v.adef = adef;
    v.vec = vec; v.rdata = rdata; v.chk = chk; v.chk_bus = chk_bus;
    v.ev = ev; v.es = es; v.epc = epc; v.einst = einst; v.eadef = eadef; v.evec = evec;
    return v;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [96:0] act, input logic [96:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, f, s1, q, input logic [64:0] m,
                       input logic [31:0] d, input logic [3:0] hi);
    reset           = r;
    flush           = f;
    stall           = {hi, s1, 1'b0};
    fs_req          = q;
    fs_to_ds_bus    = m;
    inst_sram_rdata = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t        tbl[$];
  logic [96:0] mq[$];
  logic        m_inf;
  logic [64:0] m_meta;

  initial begin
    // reset held 3 cycles with fs_req high
    tbl.push_back(mk(1,0,0,1, 32'h1c00_0000,0,32'h0,32'h0, 0,0,0,0, 32'h0,32'h0,0,32'h0));
    tbl.push_back(mk(1,0,0,1, 32'h1c00_0000,0,32'h0,32'h0, 1,1,0,0, 32'h0,32'h0,0,32'h0));
    tbl.push_back(mk(1,0,0,1, 32'h1c00_0000,0,32'h0,32'h0, 1,1,0,0, 32'h0,32'h0,0,32'h0));
    tbl.push_back(mk(0,0,0,0, 32'h0,0,32'h0,32'h0,          1,1,0,0, 32'h0,32'h0,0,32'h0));
    // single fetch
    tbl.push_back(mk(0,0,0,1, 32'h1c00_0000,0,32'h0,32'h0,          1,0,0,0, 32'h0,32'h0,0,32'h0));
    tbl.push_back(mk(0,0,0,0, 32'h0,0,32'h0,32'h0280_0000,          1,0,0,0, 32'h0,32'h0,0,32'h0));
    tbl.push_back(mk(0,0,0,0, 32'h0,0,32'h0,32'h0,                  1,1,1,0, 32'h1c00_0000,32'h0280_0000,0,32'h0));
    tbl.push_back(mk(0,0,0,0, 32'h0,0,32'h0,32'h0,                  1,0,0,0, 32'h0,32'h0,0,32'h0));
    // decode stall fill, then release
    tbl.push_back(mk(0,0,1,1, 32'h1c00_0000,0,32'h0,32'h0,          1,0,0,0, 32'h0,32'h0,0,32'h0));
    tbl.push_back(mk(0,0,1,1, 32'h1c00_0004,0,32'h0,32'h0280_0001,  1,0,0,0, 32'h0,32'h0,0,32'h0));
    tbl.push_back(mk(0,0,1,0, 32'h0,0,32'h0,32'h0280_0004,          1,1,1,1, 32'h1c00_0000,32'h0280_0001,0,32'h0));
    tbl.push_back(mk(0,0,1,0, 32'h0,0,32'h0,32'h0,                  1,1,1,1, 32'h1c00_0000,32'h0280_0001,0,32'h0));
    tbl.push_back(mk(0,0,0,0, 32'h0,0,32'h0,32'h0,                  1,1,1,1, 32'h1c00_0000,32'h0280_0001,0,32'h0));
    tbl.push_back(mk(0,0,0,0, 32'h0,0,32'h0,32'h0,                  1,1,1,0, 32'h1c00_0004,32'h0280_0004,0,32'h0));
    tbl.push_back(mk(0,0,0,0, 32'h0,0,32'h0,32'h0,                  1,0,0,0, 32'h0,32'h0,0,32'h0));
    // flush kills the in-flight fetch and ignores the flush-cycle request
    tbl.push_back(mk(0,0,0,1, 32'h1c00_0008,0,32'h0,32'h0,          1,0,0,0, 32'h0,32'h0,0,32'h0));
    tbl.push_back(mk(0,1,0,1, 32'h1c00_000c,0,32'h0,32'hdead_beef,  1,0,0,0, 32'h0,32'h0,0,32'h0));
    tbl.push_back(mk(0,0,0,0, 32'h0,0,32'h0,32'h1111_2222,          1,0,0,0, 32'h0,32'h0,0,32'h0));
    tbl.push_back(mk(0,0,0,0, 32'h0,0,32'h0,32'h0,                  1,0,0,0, 32'h0,32'h0,0,32'h0));
    // ADEF passthrough
    tbl.push_back(mk(0,0,0,1, 32'h1c00_0002,1,32'h0000_0040,32'h0,  1,0,0,0, 32'h0,32'h0,0,32'h0));
    tbl.push_back(mk(0,0,0,0, 32'h0,0,32'h0,32'h1234_5678,          1,0,0,0, 32'h0,32'h0,0,32'h0));
    tbl.push_back(mk(0,0,0,0, 32'h0,0,32'h0,32'h0,                  1,1,1,0, 32'h1c00_0002,32'h1234_5678,1,32'h0000_0040));
    tbl.push_back(mk(0,0,0,0, 32'h0,0,32'h0,32'h0,                  1,0,0,0, 32'h0,32'h0,0,32'h0));
    // flush empties a queued entry held by a decode stall
    tbl.push_back(mk(0,0,1,1, 32'h1c00_0010,0,32'h0,32'h0,          1,0,0,0, 32'h0,32'h0,0,32'h0));
    tbl.push_back(mk(0,0,1,0, 32'h0,0,32'h0,32'h0bad_0010,          1,0,0,0, 32'h0,32'h0,0,32'h0));
    tbl.push_back(mk(0,1,1,0, 32'h0,0,32'h0,32'h0,                  1,1,1,0, 32'h1c00_0010,32'h0bad_0010,0,32'h0));
    tbl.push_back(mk(0,0,0,0, 32'h0,0,32'h0,32'h0,                  1,0,0,0, 32'h0,32'h0,0,32'h0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].fl, tbl[i].st, tbl[i].rq,
            {tbl[i].vec, tbl[i].adef, tbl[i].pc}, tbl[i].rdata, 4'h0);
      if (tbl[i].chk) begin
        chk1($sformatf("tbl_valid[%0d]", i), ds_valid, tbl[i].ev);
        chk1($sformatf("tbl_stall_req[%0d]", i), fb_stall_req, tbl[i].es);
        if (tbl[i].chk_bus || tbl[i].ev)
          chkw($sformatf("tbl_bus[%0d]", i), fb_to_ds_bus,
               {tbl[i].evec, tbl[i].eadef, tbl[i].einst, tbl[i].epc});
      end
      step();
    end

    // Steady fetch, decode never stalls; fetch issues whenever not back-pressured.
    // With DEPTH=2 a queued entry plus an in-flight fetch asserts back-pressure,
    // so the pattern repeats every 3 cycles: issue, issue, hold.
    begin
      int k_issue = 0;
      int k_deliv = 0;
      int prev_k  = -1;
      for (int c = 0; c < 15; c++) begin
        logic q;
        logic [31:0] d;
        q = (c % 3 != 2);
        d = (prev_k >= 0) ? 32'h0a00_0000 + 32'(prev_k) : $urandom;
        drive(1'b0, 1'b0, 1'b0, q, {32'h0, 1'b0, 32'h1c00_0100 + 32'(4 * k_issue)}, d, 4'h0);
        chk1($sformatf("stream_stall_req[%0d]", c), fb_stall_req, (c % 3 == 2));
        chk1($sformatf("stream_valid[%0d]", c), ds_valid, (c >= 2) && (c % 3 != 1));
        if ((c >= 2) && (c % 3 != 1)) begin
          chkw($sformatf("stream_bus[%0d]", c), fb_to_ds_bus,
               {32'h0, 1'b0, 32'h0a00_0000 + 32'(k_deliv), 32'h1c00_0100 + 32'(4 * k_deliv)});
          k_deliv++;
        end
        prev_k = q ? k_issue : -1;
        if (q) k_issue++;
        step();
      end
      total++;
      if (k_deliv != 9) begin
        bad++;
        $display("FAIL stream_count: got %0d expected %0d", k_deliv, 9);
      end
    end

    // Randomized traffic against a queue model
    drive(1'b1, 1'b0, 1'b0, 1'b0, 65'h0, 32'h0, 4'h0);
    step();
    mq.delete();
    m_inf  = 1'b0;
    m_meta = 65'h0;
    for (int c = 0; c < 3000; c++) begin
      logic r, f, s1, q, exp_es, exp_ev;
      logic [64:0] meta;
      logic [31:0] d;
      r      = ($urandom_range(0, 199) == 0);
      f      = ($urandom_range(0, 19) == 0);
      s1     = ($urandom_range(0, 99) < 40);
      exp_es = ((mq.size() + int'(m_inf)) >= DEPTH);
      exp_ev = (mq.size() != 0);
      q      = !exp_es && ($urandom_range(0, 99) < 75);
      meta   = {$urandom, 1'($urandom), $urandom};
      d      = $urandom;
      drive(r, f, s1, q, meta, d, 4'($urandom));
      chk1($sformatf("rand_stall_req[%0d]", c), fb_stall_req, exp_es);
      chk1($sformatf("rand_valid[%0d]", c), ds_valid, exp_ev);
      if (exp_ev) chkw($sformatf("rand_bus[%0d]", c), fb_to_ds_bus, mq[0]);
      if (r || f) begin
        mq.delete();
        m_inf = 1'b0;
      end else begin
        if (exp_ev && !s1) void'(mq.pop_front());
        if (m_inf) mq.push_back({m_meta[64:33], m_meta[32], d, m_meta[31:0]});
        m_inf  = q;
        m_meta = meta;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
